vic_vectored: RTL and testbench
===============================

VIC_VECTORED -- requirements
Module: vic_vectored

Interface
REQ-001 Parameter NUM_INT, default 16, number of interrupt sources, legal 1..32.
REQ-002 Parameter NUM_VECT, default 8, number of vectored slots, legal 1..16; slot 0 is highest priority.
REQ-003 Parameter ADDR_BW, default 10, byte-address width.
REQ-004 Parameter DATA_BW, default 32, data width.
REQ-005 Port clk, input, 1, sole clock; all state changes on its rising edge.
REQ-006 Port rst, input, 1, reset, asynchronous, active-low.
REQ-007 Port vic_intr, input, NUM_INT, level-high interrupt requests, already synchronous to clk.
REQ-008 Port bus_en, input, 1, access strobe, one cycle per access.
REQ-009 Port bus_wr, input, 1, 1 means write, 0 means read; sampled with bus_en.
REQ-010 Port bus_addr, input, ADDR_BW, byte address; bits [1:0] ignored.
REQ-011 Port bus_wdata, input, DATA_BW, write data.
REQ-012 Port is_priviledge, input, 1, current access is privileged.
REQ-013 Port VICFIQEn / VICIRQEn, input, 1 each, global output enables.
REQ-014 Port bus_rdata, output, DATA_BW, registered read data.
REQ-015 Port bus_rvalid, output, 1, one-cycle pulse qualifying bus_rdata.
REQ-016 Port nVICFIQ / nVICIRQ, output, 1 each, registered, active-low interrupt lines.

Function
REQ-017 Register map (byte offset), shall be:
- 0x000 IRQStatus RO
- 0x004 FIQStatus RO
- 0x008 RawIntr RO
- 0x00C IntSelect RW, 1 = FIQ
- 0x010 IntEnable, write-1-set
- 0x014 IntEnClear, write-1-clear
- 0x018 SoftInt, write-1-set
- 0x01C SoftIntClear, write-1-clear
- 0x020 Protection RW, bit0
- 0x030 VectAddr
- 0x034 DefVectAddr RW
- 0x100+4n VectAddrN RW
- 0x200+4n VectCntlN RW: bit5 = enable, bits4:0 = source
REQ-018 Raw = vic_intr | SoftInt; IRQStatus = Raw & IntEnable & ~IntSelect; FIQStatus = Raw & IntEnable & IntSelect; bits at or above NUM_INT read 0 and ignore writes.
REQ-019 Read: bus_rdata and bus_rvalid appear exactly one cycle after the bus_en cycle; bus_rvalid is low otherwise; unmapped offsets read 0, and writes to them have no effect.
REQ-020 Write takes effect at the clk edge sampling bus_en; status reflects it the next cycle.
REQ-021 Slot n is a candidate when VectCntlN.enable=1, its source index < NUM_INT, and IRQStatus[source]=1.
REQ-022 Winner = lowest-numbered candidate slot not masked by in-service (REQ-024); if none, but any IRQStatus bit is set and no in-service slot exists, winner = default.
REQ-023 VectAddr read returns VectAddrN of the winner, DefVectAddr for default, 0 when no winner.
REQ-024 In-service state: NUM_VECT-bit mask plus a default flag. A VectAddr read sets the winner's bit. Slots numbered >= the highest-priority set bit are masked, and the default is masked while any bit or flag is set.
REQ-025 A VectAddr write (any data) clears the highest-priority set in-service bit, or the default flag if no bit is set; a write with none set has no effect.
REQ-026 nVICIRQ = ~(VICIRQEn & winner exists), registered, 1-cycle latency; nVICFIQ = ~(VICFIQEn & |FIQStatus), registered; FIQ bypasses priority and in-service.
REQ-027 Protection=1 with is_priviledge=0: writes ignored, reads return 0 with bus_rvalid still pulsed, VectAddr read has no side effect; Protection register itself is also locked.
REQ-028 A source deasserting after a VectAddr read leaves in-service unchanged until the write-back.
REQ-029 SoftInt set and SoftIntClear to the same bit in separate cycles: the last write wins; IntEnable/IntEnClear likewise.

Reset
REQ-030 On rst low, asynchronously: all registers 0, in-service cleared, bus_rdata 0, bus_rvalid 0, nVICFIQ 1, nVICIRQ 1; a read in flight is lost.

Verification
REQ-031 The bench shall cover the following directed scenarios:
- After reset, read every register -> all 0, nVICIRQ=1, nVICFIQ=1.
- IntEnable=0x1, vic_intr[0]=1, VICIRQEn=1 -> nVICIRQ=0 one cycle later; IRQStatus=0x1.
- VectCntl0=0x23, VectAddr0=0x1000, VectCntl1=0x21, VectAddr1=0x2000, sources 1 and 3 active -> VectAddr reads 0x1000. With slot 0 in service, a second VectAddr read returns 0; VectAddr write -> next read 0x2000.
- IntSelect=0x4, SoftInt=0x4, IntEnable=0x4, VICFIQEn=1 -> nVICFIQ=0, nVICIRQ=1; SoftIntClear=0x4 -> nVICFIQ=1.
- Protection=1, unprivileged write IntEnable=0xF -> IntEnable stays 0; unprivileged read -> rdata 0, rvalid=1.
- rst pulsed low with slot 0 in service -> in-service cleared, nVICIRQ=1 immediately.

Source files
------------

// File: rtl/vic_vectored.sv
// Vectored interrupt controller: per-source IRQ/FIQ steering, prioritised vector
// slots with in-service nesting, a default vector and privileged-access protection.
module vic_vectored #(
  parameter int NUM_INT  = 16,
  parameter int NUM_VECT = 8,
  parameter int ADDR_BW  = 10,
  parameter int DATA_BW  = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_INT-1:0] vic_intr,
  input  logic               bus_en,
  input  logic               bus_wr,
  input  logic [ADDR_BW-1:0] bus_addr,
  input  logic [DATA_BW-1:0] bus_wdata,
  input  logic               is_priviledge,
  input  logic               VICFIQEn,
  input  logic               VICIRQEn,
  output logic [DATA_BW-1:0] bus_rdata,
  output logic               bus_rvalid,
  output logic               nVICFIQ,
  output logic               nVICIRQ
);
  localparam int SLOT_BW = (NUM_VECT > 1) ? $clog2(NUM_VECT) : 1;

  localparam logic [ADDR_BW-1:0] A_IRQST = ADDR_BW'(12'h000);
  localparam logic [ADDR_BW-1:0] A_FIQST = ADDR_BW'(12'h004);
  localparam logic [ADDR_BW-1:0] A_RAW   = ADDR_BW'(12'h008);
  localparam logic [ADDR_BW-1:0] A_ISEL  = ADDR_BW'(12'h00C);
  localparam logic [ADDR_BW-1:0] A_IEN   = ADDR_BW'(12'h010);
  localparam logic [ADDR_BW-1:0] A_IENC  = ADDR_BW'(12'h014);
  localparam logic [ADDR_BW-1:0] A_SOFT  = ADDR_BW'(12'h018);
  localparam logic [ADDR_BW-1:0] A_SOFTC = ADDR_BW'(12'h01C);
  localparam logic [ADDR_BW-1:0] A_PROT  = ADDR_BW'(12'h020);
  localparam logic [ADDR_BW-1:0] A_VADDR = ADDR_BW'(12'h030);
  localparam logic [ADDR_BW-1:0] A_DEFV  = ADDR_BW'(12'h034);

  logic [NUM_INT-1:0]  r_int_select, r_int_enable, r_soft_int;
  logic                r_protection;
  logic [DATA_BW-1:0]  r_def_vect;
  logic [DATA_BW-1:0]  r_vect_addr [NUM_VECT];
  logic [5:0]          r_vect_cntl [NUM_VECT];
  logic [NUM_VECT-1:0] r_inserv;
  logic                r_inserv_def;
  logic [DATA_BW-1:0]  r_rdata;
  logic                r_rvalid, r_nfiq, r_nirq;

  logic [ADDR_BW-1:0]  w_word;
  logic [NUM_INT-1:0]  w_raw, w_irq_stat, w_fiq_stat, w_wdata_int;
  logic [31:0]         w_irq32;
  logic [NUM_VECT-1:0] w_cand, w_sel_va, w_sel_vc;
  logic                w_seen, w_win_found, w_win_def, w_win_valid;
  logic [SLOT_BW-1:0]  w_win_slot;
  logic [DATA_BW-1:0]  w_vect_rd, w_rd_data;
  logic                w_blocked, w_wr, w_rd, w_vect_ack;
  logic                w_unused_addr;

  assign w_word        = {bus_addr[ADDR_BW-1:2], 2'b00};
  assign w_unused_addr = ^bus_addr[1:0];
  assign w_wdata_int   = NUM_INT'(bus_wdata);
  assign w_raw         = vic_intr | r_soft_int;
  assign w_irq_stat    = w_raw & r_int_enable & ~r_int_select;
  assign w_fiq_stat    = w_raw & r_int_enable & r_int_select;
  assign w_irq32       = 32'(w_irq_stat);

  assign w_blocked  = r_protection & ~is_priviledge;
  assign w_wr       = bus_en & bus_wr & ~w_blocked;
  assign w_rd       = bus_en & ~bus_wr;
  assign w_vect_ack = w_rd & ~w_blocked & (w_word == A_VADDR);

  // Any set in-service bit at or below a slot's index masks that slot.
  always_comb begin
    w_cand      = '0;
    w_seen      = 1'b0;
    w_win_found = 1'b0;
    w_win_slot  = '0;
    w_sel_va    = '0;
    w_sel_vc    = '0;
    for (int n = 0; n < NUM_VECT; n++) begin
      w_cand[n] = r_vect_cntl[n][5] && ({27'd0, r_vect_cntl[n][4:0]} < 32'(NUM_INT))
                  && w_irq32[r_vect_cntl[n][4:0]];
      w_seen = w_seen | r_inserv[n];
      if (!w_win_found && !w_seen && w_cand[n]) begin
        w_win_found = 1'b1;
        w_win_slot  = SLOT_BW'(n);
      end
      w_sel_va[n] = (w_word == ADDR_BW'(32'h100 + 32'(4 * n)));
      w_sel_vc[n] = (w_word == ADDR_BW'(32'h200 + 32'(4 * n)));
    end
  end

  assign w_win_def   = ~w_win_found & (|w_irq_stat) & ~(|r_inserv) & ~r_inserv_def;
  assign w_win_valid = w_win_found | w_win_def;
  assign w_vect_rd   = w_win_found ? r_vect_addr[w_win_slot] :
                       (w_win_def ? r_def_vect : '0);

  always_comb begin
    w_rd_data = '0;
    case (w_word)
      A_IRQST: w_rd_data = DATA_BW'(w_irq_stat);
      A_FIQST: w_rd_data = DATA_BW'(w_fiq_stat);
      A_RAW:   w_rd_data = DATA_BW'(w_raw);
      A_ISEL:  w_rd_data = DATA_BW'(r_int_select);
      A_IEN:   w_rd_data = DATA_BW'(r_int_enable);
      A_SOFT:  w_rd_data = DATA_BW'(r_soft_int);
      A_PROT:  w_rd_data = DATA_BW'(r_protection);
      A_VADDR: w_rd_data = w_vect_rd;
      A_DEFV:  w_rd_data = r_def_vect;
      default: ;
    endcase
    for (int n = 0; n < NUM_VECT; n++) begin
      if (w_sel_va[n]) w_rd_data = r_vect_addr[n];
      if (w_sel_vc[n]) w_rd_data = DATA_BW'(r_vect_cntl[n]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_int_select <= '0;
      r_int_enable <= '0;
      r_soft_int   <= '0;
      r_protection <= 1'b0;
      r_def_vect   <= '0;
      for (int n = 0; n < NUM_VECT; n++) begin
        r_vect_addr[n] <= '0;
        r_vect_cntl[n] <= '0;
      end
      r_inserv     <= '0;
      r_inserv_def <= 1'b0;
      r_rdata      <= '0;
      r_rvalid     <= 1'b0;
      r_nfiq       <= 1'b1;
      r_nirq       <= 1'b1;
    end else begin
      r_rvalid <= w_rd;
      r_rdata  <= (w_rd && !w_blocked) ? w_rd_data : '0;
      r_nirq   <= ~(VICIRQEn & w_win_valid);
      r_nfiq   <= ~(VICFIQEn & (|w_fiq_stat));
      if (w_wr) begin
        case (w_word)
          A_ISEL:  r_int_select <= w_wdata_int;
          A_IEN:   r_int_enable <= r_int_enable | w_wdata_int;
          A_IENC:  r_int_enable <= r_int_enable & ~w_wdata_int;
          A_SOFT:  r_soft_int   <= r_soft_int | w_wdata_int;
          A_SOFTC: r_soft_int   <= r_soft_int & ~w_wdata_int;
          A_PROT:  r_protection <= bus_wdata[0];
          A_DEFV:  r_def_vect   <= bus_wdata;
          // Write-back retires the highest-priority (lowest) in-service slot first.
          A_VADDR: begin
            if (|r_inserv) r_inserv <= r_inserv & (r_inserv - NUM_VECT'(1));
            else           r_inserv_def <= 1'b0;
          end
          default: ;
        endcase
        for (int n = 0; n < NUM_VECT; n++) begin
          if (w_sel_va[n]) r_vect_addr[n] <= bus_wdata;
          if (w_sel_vc[n]) r_vect_cntl[n] <= bus_wdata[5:0];
        end
      end
      if (w_vect_ack) begin
        if (w_win_found)    r_inserv[w_win_slot] <= 1'b1;
        else if (w_win_def) r_inserv_def         <= 1'b1;
      end
    end
  end

  assign bus_rdata  = r_rdata;
  assign bus_rvalid = r_rvalid;
  assign nVICFIQ    = r_nfiq;
  assign nVICIRQ    = r_nirq;

endmodule

// File: tb/tb_vic_vectored.sv
// Directed bench for vic_vectored: read expectations go through a scoreboard
// queue and every comparison is an immediate assertion.
module tb_vic_vectored;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] vic_intr = '0;
  logic        bus_en = 1'b0, bus_wr = 1'b0;
  logic [9:0]  bus_addr = '0;
  logic [31:0] bus_wdata = '0;
  logic        is_priviledge = 1'b0;
  logic        VICFIQEn = 1'b0, VICIRQEn = 1'b0;
  logic [31:0] bus_rdata;
  logic        bus_rvalid, nVICFIQ, nVICIRQ;

  int n_assert = 0;
  int n_fail   = 0;
  logic [31:0] exp_q [$];
  logic [9:0]  regs [0:11];

  localparam logic [9:0] IRQST = 10'h000, FIQST = 10'h004, RAW = 10'h008, ISEL = 10'h00C;
  localparam logic [9:0] IEN = 10'h010, IENC = 10'h014, SOFT = 10'h018, SOFTC = 10'h01C;
  localparam logic [9:0] PROT = 10'h020, VADDR = 10'h030, DEFV = 10'h034;

  vic_vectored dut (
    .clk(clk), .rst(rst), .vic_intr(vic_intr),
    .bus_en(bus_en), .bus_wr(bus_wr), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .is_priviledge(is_priviledge), .VICFIQEn(VICFIQEn), .VICIRQEn(VICIRQEn),
    .bus_rdata(bus_rdata), .bus_rvalid(bus_rvalid), .nVICFIQ(nVICFIQ), .nVICIRQ(nVICIRQ)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wr(input logic [9:0] a, input logic [31:0] d);
    @(negedge clk);
    bus_en = 1'b1; bus_wr = 1'b1; bus_addr = a; bus_wdata = d;
    @(negedge clk);
    bus_en = 1'b0; bus_wr = 1'b0;
    chk("wr_rvalid_low", 32'(bus_rvalid), 32'd0);
  endtask

  task automatic rd(input string tag, input logic [9:0] a, input logic [31:0] e);
    @(negedge clk);
    bus_en = 1'b1; bus_wr = 1'b0; bus_addr = a;
    exp_q.push_back(e);
    @(negedge clk);
    bus_en = 1'b0;
    chk({tag, "_rvalid"}, 32'(bus_rvalid), 32'd1);
    if (exp_q.size() > 0) chk(tag, bus_rdata, exp_q.pop_front());
  endtask

  initial begin
    regs = '{IRQST, FIQST, RAW, ISEL, IEN, IENC, SOFT, SOFTC, PROT, VADDR, DEFV, 10'h040};
    repeat (2) @(negedge clk);
    chk("rst_nirq", 32'(nVICIRQ), 32'd1);
    chk("rst_nfiq", 32'(nVICFIQ), 32'd1);
    chk("rst_rvalid", 32'(bus_rvalid), 32'd0);
    rst = 1'b1;

    // Everything reads zero out of reset
    for (int i = 0; i < 12; i++) rd("rst_reg", regs[i], 32'h0);
    for (int n = 0; n < 8; n++) begin
      rd("rst_vaddr_n", 10'(10'h100 + 4 * n), 32'h0);
      rd("rst_vcntl_n", 10'(10'h200 + 4 * n), 32'h0);
    end
    chk("idle_nirq", 32'(nVICIRQ), 32'd1);
    chk("idle_nfiq", 32'(nVICFIQ), 32'd1);

    // Single IRQ via the default vector
    vic_intr = 16'h0001; VICIRQEn = 1'b1;
    wr(DEFV, 32'h3000);
    wr(IEN, 32'h1);
    chk("irq_latency_hi", 32'(nVICIRQ), 32'd1);
    tick();
    chk("irq_asserted", 32'(nVICIRQ), 32'd0);
    rd("irq_status", IRQST, 32'h1);
    rd("raw_intr", RAW, 32'h1);
    rd("fiq_status_0", FIQST, 32'h0);
    rd("def_vect", VADDR, 32'h3000);
    chk("def_nirq_still_lo", 32'(nVICIRQ), 32'd0);
    rd("def_masked", VADDR, 32'h0);
    chk("def_inserv_nirq", 32'(nVICIRQ), 32'd1);
    wr(VADDR, 32'h0);
    chk("def_wb_nirq_hi", 32'(nVICIRQ), 32'd1);
    tick();
    chk("def_wb_nirq_lo", 32'(nVICIRQ), 32'd0);
    vic_intr = '0;
    wr(IENC, 32'hFFFF);
    rd("ienc_cleared", IEN, 32'h0);

    // Vectored priority, in-service masking and nesting
    wr(10'h200, 32'h23); wr(10'h100, 32'h1000);
    wr(10'h204, 32'h21); wr(10'h104, 32'h2000);
    rd("vcntl0_rb", 10'h200, 32'h23);
    rd("vaddr1_rb", 10'h104, 32'h2000);
    vic_intr = 16'h000A;
    wr(IEN, 32'hA);
    rd("slot0_wins", VADDR, 32'h1000);
    rd("slot0_inserv", VADDR, 32'h0);
    chk("all_masked_nirq", 32'(nVICIRQ), 32'd1);
    vic_intr = 16'h0002;
    rd("src_drop_keeps", VADDR, 32'h0);
    wr(VADDR, 32'h0);
    rd("slot1_after_wb", VADDR, 32'h2000);
    vic_intr = 16'h000A;
    rd("slot0_preempts", VADDR, 32'h1000);
    rd("nested_masked", VADDR, 32'h0);
    vic_intr = 16'h0002;
    wr(VADDR, 32'h0);
    rd("slot1_still_in", VADDR, 32'h0);
    wr(VADDR, 32'h0);
    rd("slot1_again", VADDR, 32'h2000);
    wr(VADDR, 32'h0);
    wr(VADDR, 32'h0);
    rd("empty_wb_noop", VADDR, 32'h2000);
    wr(VADDR, 32'h0);
    vic_intr = '0;
    wr(IENC, 32'hFFFF);

    // FIQ steering and upper-bit masking
    wr(ISEL, 32'hFFFF_FFFF);
    rd("isel_width", ISEL, 32'h0000_FFFF);
    wr(ISEL, 32'h4);
    VICFIQEn = 1'b1;
    wr(SOFT, 32'h4);
    wr(IEN, 32'h4);
    tick();
    chk("fiq_asserted", 32'(nVICFIQ), 32'd0);
    chk("fiq_no_irq", 32'(nVICIRQ), 32'd1);
    rd("fiq_status", FIQST, 32'h4);
    rd("irq_status_0", IRQST, 32'h0);
    rd("soft_raw", RAW, 32'h4);
    rd("soft_rb", SOFT, 32'h4);
    wr(SOFTC, 32'h4);
    tick();
    chk("fiq_released", 32'(nVICFIQ), 32'd1);
    rd("soft_cleared", SOFT, 32'h0);
    wr(SOFT, 32'h8); wr(SOFTC, 32'h8);
    rd("soft_last_clr", SOFT, 32'h0);
    wr(SOFTC, 32'h8); wr(SOFT, 32'h8);
    rd("soft_last_set", SOFT, 32'h8);
    wr(SOFTC, 32'hFFFF); wr(IENC, 32'hFFFF); wr(ISEL, 32'h0);

    // Protection
    is_priviledge = 1'b1;
    wr(PROT, 32'h1);
    rd("prot_set", PROT, 32'h1);
    vic_intr = 16'h0010;
    is_priviledge = 1'b0;
    wr(IEN, 32'hF);
    rd("unpriv_read_0", RAW, 32'h0);
    wr(PROT, 32'h0);
    is_priviledge = 1'b1;
    rd("priv_raw", RAW, 32'h10);
    rd("unpriv_wr_ign", IEN, 32'h0);
    rd("prot_locked", PROT, 32'h1);
    wr(PROT, 32'h0);
    rd("prot_cleared", PROT, 32'h0);
    vic_intr = '0;

    // Asynchronous reset with slot 0 in service and a read in flight
    vic_intr = 16'h0008;
    wr(IEN, 32'h8);
    rd("pre_rst_slot0", VADDR, 32'h1000);
    wr(ISEL, 32'h4); wr(SOFT, 32'h4); wr(IEN, 32'h4);
    tick();
    chk("pre_rst_fiq", 32'(nVICFIQ), 32'd0);
    @(negedge clk);
    bus_en = 1'b1; bus_wr = 1'b0; bus_addr = RAW;
    #2 rst = 1'b0;
    #1;
    chk("arst_nfiq", 32'(nVICFIQ), 32'd1);
    chk("arst_nirq", 32'(nVICIRQ), 32'd1);
    chk("arst_rvalid", 32'(bus_rvalid), 32'd0);
    @(negedge clk);
    bus_en = 1'b0;
    chk("lost_read", 32'(bus_rvalid), 32'd0);
    rst = 1'b1;
    rd("post_rst_ien", IEN, 32'h0);
    wr(10'h200, 32'h23); wr(10'h100, 32'h1000); wr(IEN, 32'h8);
    rd("inserv_cleared", VADDR, 32'h1000);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
